// File: rtl/demux13_7_feeder.sv
// Tagged-word FIFO feeding the 13-bit 1-to-7 demux through a registered select/data stage.
// Destination-7 words are popped but never presented; they are tallied in drop_count.
module demux13_7_feeder #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 13
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [2:0]               wr_dest,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     rd_ready,
    output logic                     out_valid,
    output logic [2:0]               select,
    output logic [DATA_W-1:0]        in_value,
    output logic [7:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + 3;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   occ;
    logic [CW-1:0]   occ_nxt;

    logic            wr_accept;
    logic            load;
    logic [EW-1:0]   head;
    logic [2:0]      head_dest;
    logic            head_drop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign full      = (occ == CW'(DEPTH));
    assign empty     = (occ == '0);
    assign count     = occ;

    // A write while full is refused even if a pop frees a slot on the same edge.
    assign wr_accept = wr_en && !full && !reset;
    assign load      = !empty && (!out_valid || rd_ready);

    assign head      = mem[rd_ptr];
    assign head_dest = head[EW-1:DATA_W];
    assign head_drop = (head_dest == 3'd7);

    always_comb begin
        occ_nxt = occ;
        case ({wr_accept, load})
            2'b10:   occ_nxt = occ + CW'(1);
            2'b01:   occ_nxt = occ - CW'(1);
            default: occ_nxt = occ;
        endcase
    end

    // Storage array carries data only; no reset needed.
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr] <= {wr_dest, wr_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            occ <= occ_nxt;
            if (wr_accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (load)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

    // Output stage: load implies the presented word is gone, so a dropped head clears out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            select     <= 3'd0;
            in_value   <= '0;
            drop_count <= 8'd0;
        end else if (load) begin
            if (head_drop) begin
                out_valid  <= 1'b0;
                drop_count <= sat_inc8(drop_count);
            end else begin
                out_valid <= 1'b1;
                select    <= head_dest;
                in_value  <= head[DATA_W-1:0];
            end
        end else if (out_valid && rd_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux13_7_feeder.sv
// Directed bench for demux13_7_feeder: latency, fill/overflow, drops, back-pressure, wrap, reset.
module tb_demux13_7_feeder;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        wr_dest;
    logic              full;
    logic              empty;
    logic [2:0]        count;
    logic              overflow;
    logic              rd_ready;
    logic              out_valid;
    logic [2:0]        select;
    logic [DATA_W-1:0] in_value;
    logic [7:0]        drop_count;

    int checks   = 0;
    int failures = 0;

    demux13_7_feeder #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_dest(wr_dest),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .rd_ready(rd_ready), .out_valid(out_valid), .select(select),
        .in_value(in_value), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"},  32'(out_valid),  32'd0);
        chk({tag, "_select"},     32'(select),     32'd0);
        chk({tag, "_in_value"},   32'(in_value),   32'd0);
        chk({tag, "_count"},      32'(count),      32'd0);
        chk({tag, "_empty"},      32'(empty),      32'd1);
        chk({tag, "_full"},       32'(full),       32'd0);
        chk({tag, "_overflow"},   32'(overflow),   32'd0);
        chk({tag, "_drop_count"}, 32'(drop_count), 32'd0);
    endtask

    logic [15:0] exp_q[$];
    logic [15:0] held;
    logic        acc, pop, cons, hold;
    logic [2:0]  c0;

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; wr_dest = 3'd0; rd_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk_reset_state("reset");

        // Single word: 2-edge latency
        wr_en = 1'b1; wr_data = 13'h0E23; wr_dest = 3'd0;
        tick();
        wr_en = 1'b0;
        chk("single_count_n",  32'(count), 32'd1);
        chk("single_valid_n",  32'(out_valid), 32'd0);
        tick();
        chk("single_valid",    32'(out_valid), 32'd1);
        chk("single_select",   32'(select), 32'd0);
        chk("single_value",    32'(in_value), 32'h0E23);
        chk("single_count",    32'(count), 32'd0);
        rd_ready = 1'b1;
        tick();
        chk("single_consumed", 32'(out_valid), 32'd0);
        rd_ready = 1'b0;

        // Fill to full with back-pressure, sixth write overflows
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_en = 1'b1; wr_data = DATA_W'(13'h100 + i); wr_dest = 3'(i + 1);
            tick();
        end
        wr_en = 1'b0;
        chk("fill_full",     32'(full), 32'd1);
        chk("fill_count",    32'(count), 32'd4);
        chk("fill_overflow", 32'(overflow), 32'd1);
        chk("fill_valid",    32'(out_valid), 32'd1);
        rd_ready = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) begin
            chk($sformatf("drain%0d_valid", k),  32'(out_valid), 32'd1);
            chk($sformatf("drain%0d_select", k), 32'(select), 32'(k + 1));
            chk($sformatf("drain%0d_value", k),  32'(in_value), 32'h100 + 32'(k));
            tick();
        end
        chk("drain_done_valid", 32'(out_valid), 32'd0);
        chk("drain_done_empty", 32'(empty), 32'd1);
        chk("overflow_sticky",  32'(overflow), 32'd1);

        // Invalid destination between two valid words
        wr_en = 1'b1; wr_data = 13'h033; wr_dest = 3'd3; tick();
        wr_data = 13'h077; wr_dest = 3'd7; tick();
        chk("inv_w3_valid",  32'(out_valid), 32'd1);
        chk("inv_w3_select", 32'(select), 32'd3);
        chk("inv_w3_value",  32'(in_value), 32'h033);
        wr_data = 13'h055; wr_dest = 3'd5; tick();
        wr_en = 1'b0;
        chk("inv_drop_valid",  32'(out_valid), 32'd0);
        chk("inv_drop_count",  32'(drop_count), 32'd1);
        chk("inv_drop_hold",   32'(select), 32'd3);
        tick();
        chk("inv_w5_valid",  32'(out_valid), 32'd1);
        chk("inv_w5_select", 32'(select), 32'd5);
        chk("inv_w5_value",  32'(in_value), 32'h055);
        tick();
        chk("inv_end_valid", 32'(out_valid), 32'd0);

        // 300 dest-7 words saturate drop_count
        for (int i = 0; i < 300; i++) begin
            wr_en = 1'b1; wr_data = DATA_W'(i); wr_dest = 3'd7;
            tick();
        end
        wr_en = 1'b0;
        tick(); tick();
        chk("sat_drop_count", 32'(drop_count), 32'd255);
        chk("sat_valid",      32'(out_valid), 32'd0);
        chk("sat_empty",      32'(empty), 32'd1);

        // Back-pressure: rd_ready toggles while writing every cycle
        for (int cyc = 0; cyc < 60; cyc++) begin
            wr_en    = (cyc < 24);
            wr_data  = DATA_W'(13'h200 + cyc);
            wr_dest  = 3'(cyc % 7);
            rd_ready = (cyc < 24) ? cyc[0] : 1'b1;
            acc  = wr_en && !full;
            pop  = !empty && (!out_valid || rd_ready);
            cons = out_valid && rd_ready;
            hold = out_valid && !rd_ready;
            held = {select, in_value};
            c0   = count;
            if (acc) exp_q.push_back({wr_dest, wr_data});
            if (cons) begin
                if (exp_q.size() == 0) begin
                    chk("bp_unexpected_word", 32'(held), 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("bp_word_c%0d", cyc), 32'(held), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
            tick();
            if (hold) begin
                chk($sformatf("bp_stable_c%0d", cyc), 32'({out_valid, select, in_value}),
                    32'({1'b1, held}));
            end
            if (acc && pop)
                chk($sformatf("bp_count_c%0d", cyc), 32'(count), 32'(c0));
        end
        wr_en = 1'b0;
        chk("bp_all_delivered", 32'(exp_q.size()), 32'd0);
        chk("bp_final_valid",   32'(out_valid), 32'd0);

        // Pointer wrap: 3*DEPTH words at full rate
        rd_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            wr_en = 1'b1; wr_data = DATA_W'(i); wr_dest = 3'(i % 7);
            tick();
            if (i >= 1) begin
                chk($sformatf("wrap%0d_valid", i - 1),  32'(out_valid), 32'd1);
                chk($sformatf("wrap%0d_value", i - 1),  32'(in_value), 32'(i - 1));
                chk($sformatf("wrap%0d_select", i - 1), 32'(select), 32'((i - 1) % 7));
            end
        end
        wr_en = 1'b0;
        tick();
        chk("wrap_last_value",  32'(in_value), 32'd11);
        chk("wrap_last_select", 32'(select), 32'd4);
        tick();
        chk("wrap_end_valid",   32'(out_valid), 32'd0);

        // Mid-stream reset with 3 words buffered and a word presented
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = DATA_W'(13'h300 + i); wr_dest = 3'd2;
            tick();
        end
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        reset = 1'b1; wr_data = 13'h3FF; wr_dest = 3'd1;
        tick();
        reset = 1'b0; wr_en = 1'b0;
        chk_reset_state("midrst");
        wr_en = 1'b1; wr_data = 13'h0ABC; wr_dest = 3'd6;
        tick();
        wr_en = 1'b0;
        chk("post_rst_count", 32'(count), 32'd1);
        tick();
        chk("post_rst_valid",  32'(out_valid), 32'd1);
        chk("post_rst_select", 32'(select), 32'd6);
        chk("post_rst_value",  32'(in_value), 32'h0ABC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
